memgame_ctrl: RTL and testbench

Parametrised round sequencer for the memorization game; replaces the fixed single-shot display-phase timer at top level. Runs multi-round games:
- Latches a DIGITS-wide hex target from the random source.
- Shows the target for a window that shrinks each level.
- Accepts one keyboard entry per round, with a timeout, and compares it against the target.
- Tracks score and lives, and ends in a game-over state.
Sits between randnum/keyboard and the display driver.

---
 rtl/memgame_pkg.sv | 44 ++++
 rtl/memgame_ctrl_if.sv | 45 ++++
 rtl/phase_timer.sv | 25 ++
 rtl/memgame_ctrl.sv | 148 ++++++++++++++
 tb/tb_memgame_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memgame_pkg.sv
// Shared encodings, timer width and width/window helpers for the memory-game sequencer.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package memgame_pkg;

   // Width of the shared phase timer.
   localparam int TW = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SHOW   = 3'd2,
      INPUT  = 3'd3,
      RESULT = 3'd4,
      OVER   = 3'd5
   } state_e;

   // Width of score/level: must be able to hold maxRounds itself.
   function automatic int scoreWidth(input int maxRounds);
      return (maxRounds < 1) ? 1 : $clog2(maxRounds + 1);
   endfunction

   // Width of lives_left: must be able to hold the initial lives count.
   function automatic int livesWidth(input int lives);
      return (lives < 1) ? 1 : $clog2(lives + 1);
   endfunction

   // Display window for a level: base - lvl*step, floored at minWin, never underflowing.
   function automatic logic [TW-1:0] showWindow(input logic [TW-1:0] base,
                                                input logic [TW-1:0] step,
                                                input logic [TW-1:0] minWin,
                                                input logic [TW-1:0] lvl);
      logic [2*TW-1:0] dec;
      logic [TW-1:0]   win;
      dec = {{TW{1'b0}}, lvl} * {{TW{1'b0}}, step};
      if (dec >= {{TW{1'b0}}, base}) win = minWin;
      else                           win = base - dec[TW-1:0];
      if (win < minWin) win = minWin;
      // A zero-length window would never expire, so the shortest window is one cycle.
      if (win == '0) win = TW'(1);
      return win;
   endfunction

endpackage

// File: rtl/memgame_ctrl_if.sv
// Bundles the random/keyboard inputs and the display-side outputs of the game sequencer.
// Latency: none, wires only.
// Backpressure: none; start and user_ready are single-cycle pulses, outputs are levels.
interface memgame_ctrl_if
   import memgame_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int LIVES      = 3,
   parameter int MAX_ROUNDS = 15
);
   localparam int W  = 4 * DIGITS;
   localparam int SW = scoreWidth(MAX_ROUNDS);
   localparam int LW = livesWidth(LIVES);

   logic          start;
   logic [W-1:0]  rand_val;
   logic [W-1:0]  user_val;
   logic          user_ready;
   logic [W-1:0]  target;
   logic          display_phase;
   logic          input_phase;
   logic          result_valid;
   logic          correct;
   logic          timeout;
   logic [SW-1:0] score;
   logic [LW-1:0] lives_left;
   logic [SW-1:0] level;
   logic          game_over;
   logic [2:0]    state;

   // Controller side: consumes start/random/keyboard, drives the display outputs.
   modport master (
      input  start, rand_val, user_val, user_ready,
      output target, display_phase, input_phase, result_valid, correct, timeout,
             score, lives_left, level, game_over, state
   );

   // Peripheral side: randnum, keyboard and display driver.
   modport slave (
      output start, rand_val, user_val, user_ready,
      input  target, display_phase, input_phase, result_valid, correct, timeout,
             score, lives_left, level, game_over, state
   );

endinterface

// File: rtl/phase_timer.sv
// Loadable 32-bit down-counter; expire pulses for the one cycle the count sits at 1.
// Latency: a load of N gives expire in the N-th cycle after the load edge.
// Backpressure: none; a load always overrides the count, and a count of 0 never expires.
module phase_timer
   import memgame_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          expire
);

   logic [TW-1:0] count;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               count <= '0;
      else if (load)          count <= load_val;
      else if (count != '0)   count <= count - TW'(1);
   end

   assign expire = (count == TW'(1));

endmodule

// File: rtl/memgame_ctrl.sv
// Multi-round memory-game sequencer: latch target, show it, take one entry, score it, repeat.
// Latency: LOAD 1 cycle, SHOW = level window, INPUT <= INPUT_TIMEOUT, RESULT = RESULT_CYCLES.
// Backpressure: none; start outside IDLE/OVER and user_ready outside INPUT are dropped.
module memgame_ctrl
   import memgame_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int SHOW_CYCLES   = 500000000,
   parameter int SHOW_STEP     = 50000000,
   parameter int SHOW_MIN      = 100000000,
   parameter int INPUT_TIMEOUT = 1000000000,
   parameter int RESULT_CYCLES = 100000000,
   parameter int LIVES         = 3,
   parameter int MAX_ROUNDS    = 15
)(
   input  logic           clk,
   input  logic           rst,
   memgame_ctrl_if.master bus
);

   localparam int W  = 4 * DIGITS;
   localparam int SW = scoreWidth(MAX_ROUNDS);
   localparam int LW = livesWidth(LIVES);

   localparam logic [SW-1:0] ROUNDS_MAX  = SW'(MAX_ROUNDS);
   localparam logic [LW-1:0] LIVES_INIT  = LW'(LIVES);
   // A timeout of 0 loads 0, which the timer never expires from: entry waits forever.
   localparam logic [TW-1:0] INPUT_LOAD  = TW'(INPUT_TIMEOUT);
   localparam logic [TW-1:0] RESULT_LOAD = (RESULT_CYCLES < 1) ? TW'(1) : TW'(RESULT_CYCLES);

   state_e        curState, nextState;
   logic          timerLoad;
   logic [TW-1:0] timerVal;
   logic          timerExpire;
   logic          gameStart;
   logic          roundEnd;
   logic          entryHit;

   logic [W-1:0]  targetReg;
   logic [SW-1:0] scoreReg;
   logic [SW-1:0] levelReg;
   logic [LW-1:0] livesReg;
   logic          correctReg;
   logic          timeoutReg;

   phase_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timerLoad),
      .load_val (timerVal),
      .expire   (timerExpire)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) curState <= IDLE;
      else      curState <= nextState;
   end

   // Next state, timer reloads and round-end strobes.
   always_comb begin
      nextState = curState;
      timerLoad = 1'b0;
      timerVal  = '0;
      gameStart = 1'b0;
      roundEnd  = 1'b0;
      entryHit  = 1'b0;
      case (curState)
         IDLE, OVER: begin
            if (bus.start) begin
               nextState = LOAD;
               gameStart = 1'b1;
            end
         end
         LOAD: begin
            nextState = SHOW;
            timerLoad = 1'b1;
            timerVal  = showWindow(TW'(SHOW_CYCLES), TW'(SHOW_STEP), TW'(SHOW_MIN), TW'(levelReg));
         end
         SHOW: begin
            if (timerExpire) begin
               nextState = INPUT;
               timerLoad = 1'b1;
               timerVal  = INPUT_LOAD;
            end
         end
         INPUT: begin
            // An entry arriving on the expiry cycle beats the timeout.
            if (bus.user_ready || timerExpire) begin
               nextState = RESULT;
               timerLoad = 1'b1;
               timerVal  = RESULT_LOAD;
               roundEnd  = 1'b1;
               entryHit  = bus.user_ready && (bus.user_val == targetReg);
            end
         end
         RESULT: begin
            if (timerExpire) begin
               if ((livesReg == '0) || (levelReg == ROUNDS_MAX)) nextState = OVER;
               else                                              nextState = LOAD;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Game bookkeeping: target latch, round verdict, saturating score/lives/level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         targetReg  <= '0;
         scoreReg   <= '0;
         levelReg   <= '0;
         livesReg   <= LIVES_INIT;
         correctReg <= 1'b0;
         timeoutReg <= 1'b0;
      end else begin
         if (gameStart) begin
            scoreReg <= '0;
            levelReg <= '0;
            livesReg <= LIVES_INIT;
         end
         if (curState == LOAD) targetReg <= bus.rand_val;
         if (roundEnd) begin
            correctReg <= entryHit;
            timeoutReg <= !bus.user_ready;
            if (entryHit) begin
               if (scoreReg != ROUNDS_MAX) scoreReg <= scoreReg + SW'(1);
            end else begin
               if (livesReg != '0) livesReg <= livesReg - LW'(1);
            end
            if (levelReg != ROUNDS_MAX) levelReg <= levelReg + SW'(1);
         end
      end
   end

   assign bus.target        = targetReg;
   assign bus.display_phase = (curState == SHOW);
   assign bus.input_phase   = (curState == INPUT);
   assign bus.result_valid  = (curState == RESULT);
   assign bus.correct       = (curState == RESULT) && correctReg;
   assign bus.timeout       = (curState == RESULT) && timeoutReg;
   assign bus.score         = scoreReg;
   assign bus.lives_left    = livesReg;
   assign bus.level         = levelReg;
   assign bus.game_over     = (curState == OVER);
   assign bus.state         = curState;

endmodule

// File: tb/tb_memgame_ctrl.sv
// Directed and randomized games against a round-level reference model of the sequencer.
// Latency: checks phase lengths in cycles, sampled on the falling clock edge.
// Backpressure: exercises ignored start/user_ready pulses and entry/timeout collisions.
module tb_memgame_ctrl;

   localparam int DIGITS        = 4;
   localparam int SHOW_CYCLES   = 10;
   localparam int SHOW_STEP     = 3;
   localparam int SHOW_MIN      = 4;
   localparam int INPUT_TIMEOUT = 20;
   localparam int RESULT_CYCLES = 5;
   localparam int LIVES         = 2;
   localparam int MAX_ROUNDS    = 3;

   localparam int ST_IDLE = 0;
   localparam int ST_LOAD = 1;
   localparam int ST_OVER = 5;

   logic clk = 1'b0;
   logic rst;

   memgame_ctrl_if #(.DIGITS(DIGITS), .LIVES(LIVES), .MAX_ROUNDS(MAX_ROUNDS)) bus ();

   memgame_ctrl #(
      .DIGITS(DIGITS), .SHOW_CYCLES(SHOW_CYCLES), .SHOW_STEP(SHOW_STEP), .SHOW_MIN(SHOW_MIN),
      .INPUT_TIMEOUT(INPUT_TIMEOUT), .RESULT_CYCLES(RESULT_CYCLES), .LIVES(LIVES),
      .MAX_ROUNDS(MAX_ROUNDS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: game-level quantities only.
   int          mScore;
   int          mLives;
   int          mLevel;
   logic [15:0] mTarget;
   bit          mOver;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int expWin(input int lvl);
      int w;
      w = SHOW_CYCLES - lvl * SHOW_STEP;
      return (w < SHOW_MIN) ? SHOW_MIN : w;
   endfunction

   task automatic checkReset(input string tag);
      check({tag, "/state"},   32'(bus.state), ST_IDLE);
      check({tag, "/target"},  32'(bus.target), 0);
      check({tag, "/score"},   32'(bus.score), 0);
      check({tag, "/level"},   32'(bus.level), 0);
      check({tag, "/lives"},   32'(bus.lives_left), LIVES);
      check({tag, "/disp"},    32'(bus.display_phase), 0);
      check({tag, "/inp"},     32'(bus.input_phase), 0);
      check({tag, "/resv"},    32'(bus.result_valid), 0);
      check({tag, "/correct"}, 32'(bus.correct), 0);
      check({tag, "/timeout"}, 32'(bus.timeout), 0);
      check({tag, "/over"},    32'(bus.game_over), 0);
   endtask

   // Called at a falling edge while the DUT idles in IDLE or OVER.
   task automatic startGame(input logic [15:0] r);
      bus.start    = 1'b1;
      bus.rand_val = r;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      mScore = 0;
      mLives = LIVES;
      mLevel = 0;
      mOver  = 1'b0;
      check("start_state", 32'(bus.state), ST_LOAD);
      check("start_score", 32'(bus.score), 0);
      check("start_lives", 32'(bus.lives_left), LIVES);
      check("start_level", 32'(bus.level), 0);
   endtask

   // One round from a falling edge in LOAD. kind: 0 entry after delay, 1 timeout, 2 entry on expiry cycle.
   task automatic playRound(input logic [15:0] fixR, input int kind, input bit good,
                            input bit poke, input int delay, input bit abortRes);
      logic [15:0] r;
      logic [15:0] v;
      int          n;
      bit          entered;
      bit          expCorrect;
      r = (fixR != 16'h0000) ? fixR : 16'($urandom_range(1, 65535));
      v = good ? r : 16'h0000;
      bus.rand_val = r;
      check("load_state", 32'(bus.state), ST_LOAD);
      @(posedge clk); #1;
      bus.rand_val = ~r;
      if (poke) begin
         bus.user_val   = r;
         bus.user_ready = 1'b1;
         bus.start      = 1'b1;
      end
      mTarget = r;
      @(negedge clk);
      check("target", 32'(bus.target), 32'(r));
      n = 0;
      while (bus.display_phase === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
         bus.user_ready = 1'b0;
         bus.start      = 1'b0;
      end
      check("show_len", n, expWin(mLevel));
      check("input_phase", 32'(bus.input_phase), 1);
      check("show_score", 32'(bus.score), mScore);
      check("show_lives", 32'(bus.lives_left), mLives);
      entered = 1'b1;
      if (kind == 1) begin
         entered = 1'b0;
         n = 0;
         while (bus.input_phase === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
         end
         check("input_len", n, INPUT_TIMEOUT);
      end else begin
         if (kind == 2) begin
            repeat (INPUT_TIMEOUT - 1) @(negedge clk);
            check("expiry_inp", 32'(bus.input_phase), 1);
         end else begin
            repeat (delay) @(negedge clk);
         end
         bus.user_val   = v;
         bus.user_ready = 1'b1;
         @(posedge clk); #1;
         bus.user_ready = 1'b0;
         @(negedge clk);
      end
      expCorrect = entered && (v == r);
      if (expCorrect) begin
         if (mScore < MAX_ROUNDS) mScore++;
      end else if (mLives > 0) begin
         mLives--;
      end
      mLevel++;
      mOver = (mLives == 0) || (mLevel == MAX_ROUNDS);
      check("result_valid", 32'(bus.result_valid), 1);
      check("correct", 32'(bus.correct), 32'(expCorrect));
      check("timeout", 32'(bus.timeout), 32'(!entered));
      check("score", 32'(bus.score), mScore);
      check("lives", 32'(bus.lives_left), mLives);
      check("level", 32'(bus.level), mLevel);
      if (abortRes) begin
         rst = 1'b0;
         #1;
         checkReset("rst_result");
         @(negedge clk);
         rst   = 1'b1;
         mOver = 1'b0;
      end else begin
         n = 0;
         while (bus.result_valid === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
         end
         check("result_len", n, RESULT_CYCLES);
         check("game_over", 32'(bus.game_over), 32'(mOver));
         check("next_state", 32'(bus.state), mOver ? ST_OVER : ST_LOAD);
         if (mOver) check("over_target", 32'(bus.target), 32'(mTarget));
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.rand_val   = 16'h0000;
      bus.user_val   = 16'h0000;
      bus.user_ready = 1'b0;
      #1 rst = 1'b0;
      #2 checkReset("por");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_after_rst", 32'(bus.state), ST_IDLE);

      // Game 1: three correct rounds, windows 10/7/4, ends at MAX_ROUNDS.
      startGame(16'h1A2B);
      playRound(16'h1A2B, 0, 1'b1, 1'b0, 2, 1'b0);
      playRound(16'h0000, 0, 1'b1, 1'b0, 0, 1'b0);
      playRound(16'h0000, 0, 1'b1, 1'b0, 5, 1'b0);
      repeat (3) @(negedge clk);
      check("over_hold_state", 32'(bus.state), ST_OVER);
      check("over_hold_score", 32'(bus.score), 3);

      // Game 2: two wrong entries (first with ignored SHOW-time pokes) exhaust lives.
      startGame(16'($urandom));
      playRound(16'h0000, 0, 1'b0, 1'b1, 3, 1'b0);
      playRound(16'h0000, 0, 1'b0, 1'b0, 1, 1'b0);

      // Game 3: timeout, then entries landing on the expiry cycle.
      startGame(16'($urandom));
      playRound(16'h0000, 1, 1'b0, 1'b0, 0, 1'b0);
      playRound(16'h0000, 2, 1'b1, 1'b0, 0, 1'b0);
      playRound(16'h0000, 2, 1'b0, 1'b0, 0, 1'b0);

      // Reset during SHOW.
      startGame(16'($urandom));
      repeat (2) @(negedge clk);
      check("pre_rst_disp", 32'(bus.display_phase), 1);
      rst = 1'b0;
      #1 checkReset("rst_show");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_show", 32'(bus.state), ST_IDLE);

      // Reset during RESULT.
      startGame(16'($urandom));
      playRound(16'h0000, 0, 1'b1, 1'b1, 0, 1'b1);
      check("post_rst_result", 32'(bus.state), ST_IDLE);

      // Randomized games.
      for (int g = 0; g < 5; g++) begin
         startGame(16'($urandom));
         for (int rd = 0; rd < MAX_ROUNDS && !mOver; rd++) begin
            playRound(16'h0000, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 8)), 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
